// File: rtl/axi4_burst_ram_slave.sv
// rtl/axi4_burst_ram_slave.sv - AXI4 burst slave over a 64 x 32-bit RAM
// Independent write and read FSMs; INCR/FIXED bursts, WRAP/reserved answered with SLVERR.
module axi4_burst_ram_slave #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,
   input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_awid,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [7:0]                        s00_axi_awlen,
   input  logic [1:0]                        s00_axi_awburst,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wlast,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_bid,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_arid,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [7:0]                        s00_axi_arlen,
   input  logic [1:0]                        s00_axi_arburst,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_rid,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rlast,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready
);
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [0:63];

   w_state_t                      r_wstate;
   logic                          r_awready, r_wready, r_bvalid;
   logic [1:0]                    r_bresp;
   logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
   logic [7:0]                    r_wlen, r_wcnt;
   logic [5:0]                    r_widx;
   logic                          r_wfixed, r_wbad, r_werr;

   r_state_t                      r_rstate;
   logic                          r_arready, r_rvalid, r_rlast;
   logic [1:0]                    r_rresp;
   logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [7:0]                    r_rlen, r_rcnt;
   logic [5:0]                    r_ridx;
   logic                          r_rfixed, r_rbad;

   logic       w_wbeat, w_wfinal, w_werr_now, w_mem_we, w_aw_bad;
   logic       w_rbeat, w_ar_bad;
   logic [5:0] w_ridx_next;
   logic       w_unused;

   assign w_wbeat     = (r_wstate == W_DATA) && s00_axi_wvalid && r_wready;
   assign w_wfinal    = (r_wcnt == r_wlen);
   assign w_werr_now  = r_werr || (s00_axi_wlast != w_wfinal);
   assign w_mem_we    = w_wbeat && !r_wbad;
   assign w_aw_bad    = (s00_axi_awburst != BURST_FIXED) && (s00_axi_awburst != BURST_INCR);
   assign w_rbeat     = r_rvalid && s00_axi_rready;
   assign w_ar_bad    = (s00_axi_arburst != BURST_FIXED) && (s00_axi_arburst != BURST_INCR);
   assign w_ridx_next = r_rfixed ? r_ridx : r_ridx + 6'd1;
   assign w_unused    = &{1'b0, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // RAM is never cleared so its contents survive a reset
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_areset && w_mem_we) begin
         for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
            if (s00_axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_bid     <= '0;
         r_wlen    <= '0;
         r_wcnt    <= '0;
         r_widx    <= '0;
         r_wfixed  <= 1'b0;
         r_wbad    <= 1'b0;
         r_werr    <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (s00_axi_awvalid && r_awready) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_bid     <= s00_axi_awid;
                  r_wlen    <= s00_axi_awlen;
                  r_wcnt    <= '0;
                  r_widx    <= s00_axi_awaddr[7:2];
                  r_wfixed  <= (s00_axi_awburst == BURST_FIXED);
                  r_wbad    <= w_aw_bad;
                  r_werr    <= 1'b0;
                  r_wstate  <= W_DATA;
               end else begin
                  r_awready <= 1'b1;
               end
            end
            W_DATA: begin
               // Beat count alone ends the burst; a misplaced wlast only taints the response
               if (w_wbeat) begin
                  r_werr <= w_werr_now;
                  if (w_wfinal) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_wbad || w_werr_now) ? RESP_SLVERR : RESP_OKAY;
                     r_wstate <= W_RESP;
                  end else begin
                     r_wcnt <= r_wcnt + 8'd1;
                     if (!r_wfixed) r_widx <= r_widx + 6'd1;
                  end
               end
            end
            W_RESP: begin
               if (s00_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rlen    <= '0;
         r_rcnt    <= '0;
         r_ridx    <= '0;
         r_rfixed  <= 1'b0;
         r_rbad    <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (s00_axi_arvalid && r_arready) begin
                  r_arready <= 1'b0;
                  r_rid     <= s00_axi_arid;
                  r_rlen    <= s00_axi_arlen;
                  r_rcnt    <= '0;
                  r_ridx    <= s00_axi_araddr[7:2];
                  r_rfixed  <= (s00_axi_arburst == BURST_FIXED);
                  r_rbad    <= w_ar_bad;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= w_ar_bad ? '0 : r_mem[s00_axi_araddr[7:2]];
                  r_rresp   <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
                  r_rlast   <= (s00_axi_arlen == 8'd0);
                  r_rstate  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               // Next beat is fetched on the handshake, so a same-cycle write is not yet visible
               if (w_rbeat) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_rcnt  <= r_rcnt + 8'd1;
                     r_ridx  <= w_ridx_next;
                     r_rdata <= r_rbad ? '0 : r_mem[w_ridx_next];
                     r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_wready;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_bresp   = r_bresp;
   assign s00_axi_bid     = r_bid;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rvalid  = r_rvalid;
   assign s00_axi_rlast   = r_rlast;
   assign s00_axi_rresp   = r_rresp;
   assign s00_axi_rid     = r_rid;
   assign s00_axi_rdata   = r_rdata;
endmodule

// File: doc/axi4_burst_ram_slave.md
AXI4_BURST_RAM_SLAVE -- requirements
Module: axi4_burst_ram_slave

Interface
REQ-001 The block SHALL have parameter C_S_AXI_ID_WIDTH, default 1, giving the AXI ID width.
REQ-002 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the data width; only 32 is supported.
REQ-003 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, giving the byte address width (64-word memory).
REQ-004 s00_axi_aclk  in  1  the single clock; all logic on rising edge.
REQ-005 s00_axi_areset  in  1  synchronous, active-high reset.
REQ-006 s00_axi_awid  in  ID  write burst ID.
REQ-007 s00_axi_awaddr  in  ADDR  write start byte address.
REQ-008 s00_axi_awlen  in  8  write beats minus 1.
REQ-009 s00_axi_awburst  in  2  write burst type.
REQ-010 s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
REQ-011 s00_axi_wdata  in  32  write beat data.
REQ-012 s00_axi_wstrb  in  4  byte enables.
REQ-013 s00_axi_wlast  in  1  last write beat marker.
REQ-014 s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
REQ-015 s00_axi_bid  out  ID  echoed AWID.
REQ-016 s00_axi_bresp  out  2  write response.
REQ-017 s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
REQ-018 s00_axi_arid  in  ID  read burst ID.
REQ-019 s00_axi_araddr  in  ADDR  read start byte address.
REQ-020 s00_axi_arlen  in  8  read beats minus 1.
REQ-021 s00_axi_arburst  in  2  read burst type.
REQ-022 s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
REQ-023 s00_axi_rid  out  ID  echoed ARID.
REQ-024 s00_axi_rdata  out  32  read beat data.
REQ-025 s00_axi_rresp  out  2  read response.
REQ-026 s00_axi_rlast  out  1  last read beat marker.
REQ-027 s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.

Function
REQ-028 The block SHALL hold 64 x 32-bit words indexed by addr[7:2], with addr[1:0] ignored and the size fixed at 4 bytes.
REQ-029 The write FSM SHALL be W_IDLE (awready=1) -> W_DATA (wready=1) on AW handshake, -> W_RESP (bvalid=1) on the beat where count==awlen, -> W_IDLE on bready.
REQ-030 Each W handshake SHALL update only the bytes enabled by wstrb, in that cycle.
REQ-031 INCR bursts SHALL advance the word index by 1 per beat, wrapping modulo 64; FIXED bursts SHALL reuse the start index.
REQ-032 A WRAP or reserved burst type SHALL be fully accepted with no memory writes, bresp=SLVERR(2'b10); otherwise bresp=OKAY.
REQ-033 A wlast value not equal to (count==awlen) on any beat SHALL force bresp=SLVERR; termination is by beat count only.
REQ-034 The read FSM SHALL be R_IDLE (arready=1) -> R_DATA on AR handshake; rvalid SHALL rise the next cycle with beat 0.
REQ-035 On each R handshake the next beat SHALL be presented the following cycle, giving back-to-back beats when rready is held high.
REQ-036 rdata, rid, rresp and rlast SHALL stay stable while rvalid=1 and rready=0; rlast=1 only on beat arlen; R_DATA -> R_IDLE on the last handshake.
REQ-037 A WRAP or reserved read SHALL return arlen+1 beats with rdata=0 and rresp=SLVERR.
REQ-038 Read and write channels SHALL run concurrently; a read beat loaded in the same cycle as a write to that word SHALL return the pre-write value.
REQ-039 Each direction SHALL allow one outstanding burst; awready and arready SHALL be 0 outside their IDLE states.

Reset
REQ-040 With areset=1 at a clock edge, both FSMs SHALL go to IDLE and awready, wready, bvalid, arready, rvalid, rlast SHALL be 0, with bresp, rresp, bid, rid, rdata = 0.
REQ-041 awready and arready SHALL be 1 in the first cycle after reset deasserts.
REQ-042 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL be preserved.

Verification
REQ-043 INCR write of 8 beats (data 1..8) at addr 0x00, id 0, then INCR read of 8 beats at 0x00 -> rdata 1..8 in order, rlast on beat 8, bresp and rresp OKAY.
REQ-044 Write 0xAABBCCDD with wstrb=4'b0101 over 0x00000000 at 0x10, then read -> 0x00BB00DD.
REQ-045 INCR write of 4 beats at 0xF8 -> words 62, 63, 0, 1 written (wrap modulo 64).
REQ-046 WRAP write with awid=1 -> bresp=SLVERR, bid=1, memory unchanged; WRAP read -> all beats 0 with SLVERR.
REQ-047 Read burst with rready toggling 1/0 -> rdata held while stalled, no beats lost or duplicated.
REQ-048 areset pulsed during beat 3 of an 8-beat write -> no bvalid; awready=1 the next cycle; beats 1-2 remain in memory.
